// File: rtl/rv64i_multicycle_control_unit.sv
// Multicycle control FSM for the RV64I core: sequences fetch/decode/execute/memory
// and decodes opcode/funct3/funct7 into the 25-bit datapath control word.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | reset/power-up, all outputs low
// S_FETCH    | instruction fetch request, wait for busy 1 -> 0
// S_DECODE   | one quiet cycle while the instruction settles, word latched
// S_EXECUTE  | decoded word driven; non-memory ops strobe the PC and leave
// S_MEM_DONE | memory access finished: PC strobe, load write-back
module rv64i_multicycle_control_unit (
   input  logic       clock,
   input  logic       reset,
   output logic       instruction_mem_enable,
   input  logic       instruction_mem_busy,
   output logic       data_mem_enable,
   output logic [7:0] data_mem_byte_write_enable,
   input  logic       data_mem_busy,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       zero,
   input  logic       negative,
   input  logic       carry_out,
   input  logic       overflow,
   output logic       alua_src,
   output logic       alub_src,
   output logic       aluy_src,
   output logic [2:0] alu_src,
   output logic       sub,
   output logic       arithmetic,
   output logic       alupc_src,
   output logic       pc_src,
   output logic       pc_enable,
   output logic [2:0] read_data_src,
   output logic [1:0] write_register_src,
   output logic       write_register_enable
);

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM_DONE
   } state_t;

   typedef struct packed {
      logic       alua;
      logic       alub;
      logic       aluy;
      logic [2:0] alu_src;
      logic       sub;
      logic       arithmetic;
      logic       alupc;
      logic       pc_src;
      logic [2:0] read_data_src;
      logic [1:0] write_register_src;
      logic       write_register_enable;
      logic       data_mem_enable;
      logic [7:0] byte_write_enable;
   } ctrl_t;

   state_t     state;
   ctrl_t      ctrl_q;
   ctrl_t      dec;
   logic       dec_mem;
   logic       dec_load;
   logic       dec_branch;
   logic       is_mem;
   logic       is_load;
   logic       is_branch;
   logic [2:0] br_funct3;
   logic       busy_seen;
   logic       branch_taken;
   logic       i_type;
   logic       unused_funct7_lsb;

   assign unused_funct7_lsb = funct7[0];
   assign i_type = ~opcode[5];

   always_comb begin
      dec        = '0;
      dec_mem    = 1'b0;
      dec_load   = 1'b0;
      dec_branch = 1'b0;
      case (opcode)
         OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32: begin
            dec.alub    = i_type;
            dec.aluy    = opcode[3];
            dec.alu_src = funct3;
            dec.sub     = (funct3[2:1] == 2'b01)
                          || (!i_type && funct3 == 3'b000 && funct7[5]);
            // immediate shifts keep funct7[0] as shamt[5], so only [6:1] qualify SRA
            dec.arithmetic = (funct3 == 3'b101)
                             && (i_type ? (funct7[6:1] == 6'b010000) : funct7[5]);
            dec.write_register_enable = 1'b1;
         end
         OPC_LUI: begin
            dec.alub                  = 1'b1;
            dec.write_register_src    = 2'b11;
            dec.write_register_enable = 1'b1;
         end
         OPC_AUIPC: begin
            dec.alua                  = 1'b1;
            dec.alub                  = 1'b1;
            dec.write_register_enable = 1'b1;
         end
         OPC_JAL: begin
            dec.pc_src                = 1'b1;
            dec.write_register_src    = 2'b10;
            dec.write_register_enable = 1'b1;
         end
         OPC_JALR: begin
            dec.pc_src                = 1'b1;
            dec.alupc                 = 1'b1;
            dec.write_register_src    = 2'b10;
            dec.write_register_enable = 1'b1;
         end
         OPC_BRANCH: begin
            dec.sub    = 1'b1;
            dec_branch = 1'b1;
         end
         OPC_LOAD: begin
            dec.alub               = 1'b1;
            dec.read_data_src      = funct3;
            dec.write_register_src = 2'b01;
            dec.data_mem_enable    = 1'b1;
            dec_mem                = 1'b1;
            dec_load               = 1'b1;
         end
         OPC_STORE: begin
            dec.alub            = 1'b1;
            dec.data_mem_enable = 1'b1;
            dec_mem             = 1'b1;
            case (funct3[1:0])
               2'b00:   dec.byte_write_enable = 8'h01;
               2'b01:   dec.byte_write_enable = 8'h03;
               2'b10:   dec.byte_write_enable = 8'h0F;
               default: dec.byte_write_enable = 8'hFF;
            endcase
         end
         default: ;
      endcase
   end

   // flags come from the ALU operation in flight, so the branch decision stays combinational
   always_comb begin
      branch_taken = 1'b0;
      case (br_funct3[2:1])
         2'b00:   branch_taken = zero ^ br_funct3[0];
         2'b10:   branch_taken = negative ^ overflow ^ br_funct3[0];
         2'b11:   branch_taken = ~(carry_out ^ br_funct3[0]);
         default: branch_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state                  <= S_IDLE;
         ctrl_q                 <= '0;
         instruction_mem_enable <= 1'b0;
         pc_enable              <= 1'b0;
         is_mem                 <= 1'b0;
         is_load                <= 1'b0;
         is_branch              <= 1'b0;
         br_funct3              <= 3'b000;
         busy_seen              <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state                  <= S_FETCH;
               instruction_mem_enable <= 1'b1;
               busy_seen              <= 1'b0;
            end
            S_FETCH: begin
               if (instruction_mem_busy) begin
                  busy_seen <= 1'b1;
               end else if (busy_seen) begin
                  state                  <= S_DECODE;
                  instruction_mem_enable <= 1'b0;
                  busy_seen              <= 1'b0;
               end
            end
            S_DECODE: begin
               state     <= S_EXECUTE;
               ctrl_q    <= dec;
               is_mem    <= dec_mem;
               is_load   <= dec_load;
               is_branch <= dec_branch;
               br_funct3 <= funct3;
               pc_enable <= ~dec_mem;
            end
            S_EXECUTE: begin
               if (!is_mem) begin
                  state                  <= S_FETCH;
                  ctrl_q                 <= '0;
                  is_branch              <= 1'b0;
                  pc_enable              <= 1'b0;
                  instruction_mem_enable <= 1'b1;
               end else if (data_mem_busy) begin
                  busy_seen <= 1'b1;
               end else if (busy_seen) begin
                  state                        <= S_MEM_DONE;
                  busy_seen                    <= 1'b0;
                  ctrl_q.data_mem_enable       <= 1'b0;
                  ctrl_q.byte_write_enable     <= 8'h00;
                  ctrl_q.write_register_enable <= is_load;
                  pc_enable                    <= 1'b1;
               end
            end
            S_MEM_DONE: begin
               state                  <= S_FETCH;
               ctrl_q                 <= '0;
               is_mem                 <= 1'b0;
               is_load                <= 1'b0;
               pc_enable              <= 1'b0;
               instruction_mem_enable <= 1'b1;
            end
            default: begin
               state                  <= S_IDLE;
               ctrl_q                 <= '0;
               instruction_mem_enable <= 1'b0;
               pc_enable              <= 1'b0;
            end
         endcase
      end
   end

   assign alua_src                   = ctrl_q.alua;
   assign alub_src                   = ctrl_q.alub;
   assign aluy_src                   = ctrl_q.aluy;
   assign alu_src                    = ctrl_q.alu_src;
   assign sub                        = ctrl_q.sub;
   assign arithmetic                 = ctrl_q.arithmetic;
   assign alupc_src                  = ctrl_q.alupc;
   assign pc_src                     = ctrl_q.pc_src | (is_branch & branch_taken);
   assign read_data_src              = ctrl_q.read_data_src;
   assign write_register_src         = ctrl_q.write_register_src;
   assign write_register_enable      = ctrl_q.write_register_enable;
   assign data_mem_enable            = ctrl_q.data_mem_enable;
   assign data_mem_byte_write_enable = ctrl_q.byte_write_enable;

endmodule

// File: tb/tb_rv64i_multicycle_control_unit.sv
// Bench for rv64i_multicycle_control_unit: directed instructions push expected output
// vectors (with hold lengths) into a queue; a negedge monitor compares each change.
module tb_rv64i_multicycle_control_unit;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       instruction_mem_enable;
   logic       instruction_mem_busy = 1'b0;
   logic       data_mem_enable;
   logic [7:0] data_mem_byte_write_enable;
   logic       data_mem_busy = 1'b0;
   logic [6:0] opcode = '0;
   logic [2:0] funct3 = '0;
   logic [6:0] funct7 = '0;
   logic       zero = 1'b0, negative = 1'b0, carry_out = 1'b0, overflow = 1'b0;
   logic       alua_src, alub_src, aluy_src, sub, arithmetic, alupc_src, pc_src, pc_enable;
   logic [2:0] alu_src, read_data_src;
   logic [1:0] write_register_src;
   logic       write_register_enable;

   always #5 clock = ~clock;

   rv64i_multicycle_control_unit dut (
      .clock(clock), .reset(reset),
      .instruction_mem_enable(instruction_mem_enable),
      .instruction_mem_busy(instruction_mem_busy),
      .data_mem_enable(data_mem_enable),
      .data_mem_byte_write_enable(data_mem_byte_write_enable),
      .data_mem_busy(data_mem_busy),
      .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .zero(zero), .negative(negative), .carry_out(carry_out), .overflow(overflow),
      .alua_src(alua_src), .alub_src(alub_src), .aluy_src(aluy_src),
      .alu_src(alu_src), .sub(sub), .arithmetic(arithmetic),
      .alupc_src(alupc_src), .pc_src(pc_src), .pc_enable(pc_enable),
      .read_data_src(read_data_src), .write_register_src(write_register_src),
      .write_register_enable(write_register_enable)
   );

   // {instruction_mem_enable, pc_enable, 25-bit control word}
   logic [26:0] vec;
   assign vec = {instruction_mem_enable, pc_enable, alua_src, alub_src, aluy_src, alu_src,
                 sub, arithmetic, alupc_src, pc_src, read_data_src, write_register_src,
                 write_register_enable, data_mem_enable, data_mem_byte_write_enable};

   typedef struct {
      string       name;
      logic [26:0] v;
      int          len;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        e;
   int          checks = 0;
   int          failures = 0;
   logic        mon_en = 1'b0;
   logic [26:0] prev = '1;
   int          cur_len = 0;
   int          run_len = 0;
   string       cur_name = "none";

   always @(negedge clock) begin
      if (mon_en) begin
         if (vec !== prev) begin
            if (cur_len != 0) begin
               checks++;
               if (run_len != cur_len) begin
                  failures++;
                  $display("FAIL %s_cycles got=%0d exp=%0d", cur_name, run_len, cur_len);
               end
            end
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output got=%h exp=none", vec);
               cur_len  = 0;
               cur_name = "unexpected";
            end else begin
               e = sb_q.pop_front();
               checks++;
               if (vec !== e.v) begin
                  failures++;
                  $display("FAIL %s got=%h exp=%h", e.name, vec, e.v);
               end
               cur_len  = e.len;
               cur_name = e.name;
            end
            prev    = vec;
            run_len = 1;
         end else begin
            run_len++;
         end
      end
   end

   function automatic logic [24:0] w(input logic alua, input logic alub, input logic aluy,
                                     input logic [2:0] alu, input logic sb, input logic ar,
                                     input logic apc, input logic psrc, input logic [2:0] rds,
                                     input logic [1:0] wrs, input logic wre, input logic dme,
                                     input logic [7:0] bwe);
      return {alua, alub, aluy, alu, sb, ar, apc, psrc, rds, wrs, wre, dme, bwe};
   endfunction

   task automatic push(input string n, input logic [26:0] v, input int len);
      exp_t x;
      x.name = n;
      x.v    = v;
      x.len  = len;
      sb_q.push_back(x);
   endtask

   task automatic wait_ime(input string n);
      for (int i = 0; i < 50; i++) begin
         @(posedge clock); #1;
         if (instruction_mem_enable) return;
      end
      checks++;
      failures++;
      $display("FAIL %s_fetch_timeout got=0 exp=1", n);
   endtask

   task automatic wait_dme(input string n);
      for (int i = 0; i < 50; i++) begin
         if (data_mem_enable) return;
         @(posedge clock); #1;
      end
      checks++;
      failures++;
      $display("FAIL %s_mem_timeout got=0 exp=1", n);
   endtask

   task automatic run(input string n, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic z, input logic ng, input logic c,
                      input logic ov, input logic [24:0] exw, input logic mem,
                      input logic [24:0] donew, input logic abort);
      push({n, "_fetch"}, {1'b1, 1'b0, 25'd0}, 0);
      push({n, "_decode"}, 27'd0, 1);
      push({n, "_exec"}, {1'b0, ~mem, exw}, mem ? 0 : 1);
      if (mem && !abort) push({n, "_memdone"}, {1'b0, 1'b1, donew}, 1);
      if (abort) push({n, "_reset_idle"}, 27'd0, 1);
      wait_ime(n);
      opcode = op; funct3 = f3; funct7 = f7;
      zero = z; negative = ng; carry_out = c; overflow = ov;
      instruction_mem_busy = 1'b1;
      #12;
      instruction_mem_busy = 1'b0;
      if (mem) begin
         wait_dme(n);
         @(posedge clock); #1;
         if (abort) begin
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
         end else begin
            data_mem_busy = 1'b1;
            #12;
            data_mem_busy = 1'b0;
         end
      end
   endtask

   initial begin
      @(posedge clock); #1;
      push("reset_idle", 27'd0, 1);
      mon_en = 1'b1;
      reset  = 1'b0;

      run("addi",  7'b0010011, 3'b000, 7'b0000000, 0,0,0,0,
          w(0,1,0,3'b000,0,0,0,0,3'b000,2'b00,1,0,8'h00), 0, '0, 0);
      run("srai",  7'b0010011, 3'b101, 7'b0100000, 0,0,0,0,
          w(0,1,0,3'b101,0,1,0,0,3'b000,2'b00,1,0,8'h00), 0, '0, 0);
      run("srai_sh63", 7'b0010011, 3'b101, 7'b0100001, 0,0,0,0,
          w(0,1,0,3'b101,0,1,0,0,3'b000,2'b00,1,0,8'h00), 0, '0, 0);
      run("srli_sh32", 7'b0010011, 3'b101, 7'b0000001, 0,0,0,0,
          w(0,1,0,3'b101,0,0,0,0,3'b000,2'b00,1,0,8'h00), 0, '0, 0);
      run("sub",   7'b0110011, 3'b000, 7'b0100000, 0,0,0,0,
          w(0,0,0,3'b000,1,0,0,0,3'b000,2'b00,1,0,8'h00), 0, '0, 0);
      run("sltiu", 7'b0010011, 3'b011, 7'b0000000, 0,0,0,0,
          w(0,1,0,3'b011,1,0,0,0,3'b000,2'b00,1,0,8'h00), 0, '0, 0);
      run("sraw",  7'b0111011, 3'b101, 7'b0100000, 0,0,0,0,
          w(0,0,1,3'b101,0,1,0,0,3'b000,2'b00,1,0,8'h00), 0, '0, 0);
      run("beq_z1", 7'b1100011, 3'b000, 7'b0000000, 1,0,0,0,
          w(0,0,0,3'b000,1,0,0,1,3'b000,2'b00,0,0,8'h00), 0, '0, 0);
      run("bne_z1", 7'b1100011, 3'b001, 7'b0000000, 1,0,0,0,
          w(0,0,0,3'b000,1,0,0,0,3'b000,2'b00,0,0,8'h00), 0, '0, 0);
      run("blt_n1v0", 7'b1100011, 3'b100, 7'b0000000, 0,1,0,0,
          w(0,0,0,3'b000,1,0,0,1,3'b000,2'b00,0,0,8'h00), 0, '0, 0);
      run("bge_n1v1", 7'b1100011, 3'b101, 7'b0000000, 0,1,0,1,
          w(0,0,0,3'b000,1,0,0,1,3'b000,2'b00,0,0,8'h00), 0, '0, 0);
      run("bgeu_c0", 7'b1100011, 3'b111, 7'b0000000, 0,0,0,0,
          w(0,0,0,3'b000,1,0,0,0,3'b000,2'b00,0,0,8'h00), 0, '0, 0);
      run("bltu_c0", 7'b1100011, 3'b110, 7'b0000000, 0,0,0,0,
          w(0,0,0,3'b000,1,0,0,1,3'b000,2'b00,0,0,8'h00), 0, '0, 0);
      run("lui",   7'b0110111, 3'b000, 7'b0000000, 0,0,0,0,
          w(0,1,0,3'b000,0,0,0,0,3'b000,2'b11,1,0,8'h00), 0, '0, 0);
      run("auipc", 7'b0010111, 3'b000, 7'b0000000, 0,0,0,0,
          w(1,1,0,3'b000,0,0,0,0,3'b000,2'b00,1,0,8'h00), 0, '0, 0);
      run("jal",   7'b1101111, 3'b000, 7'b0000000, 0,0,0,0,
          w(0,0,0,3'b000,0,0,0,1,3'b000,2'b10,1,0,8'h00), 0, '0, 0);
      run("jalr",  7'b1100111, 3'b000, 7'b0000000, 0,0,0,0,
          w(0,0,0,3'b000,0,0,1,1,3'b000,2'b10,1,0,8'h00), 0, '0, 0);
      run("unknown", 7'b1111111, 3'b111, 7'b1111111, 0,0,0,0,
          25'd0, 0, '0, 0);
      run("sw",    7'b0100011, 3'b010, 7'b0000000, 0,0,0,0,
          w(0,1,0,3'b000,0,0,0,0,3'b000,2'b00,0,1,8'h0F), 1,
          w(0,1,0,3'b000,0,0,0,0,3'b000,2'b00,0,0,8'h00), 0);
      run("sb",    7'b0100011, 3'b000, 7'b0000000, 0,0,0,0,
          w(0,1,0,3'b000,0,0,0,0,3'b000,2'b00,0,1,8'h01), 1,
          w(0,1,0,3'b000,0,0,0,0,3'b000,2'b00,0,0,8'h00), 0);
      run("sd",    7'b0100011, 3'b011, 7'b0000000, 0,0,0,0,
          w(0,1,0,3'b000,0,0,0,0,3'b000,2'b00,0,1,8'hFF), 1,
          w(0,1,0,3'b000,0,0,0,0,3'b000,2'b00,0,0,8'h00), 0);
      run("ld",    7'b0000011, 3'b011, 7'b0000000, 0,0,0,0,
          w(0,1,0,3'b000,0,0,0,0,3'b011,2'b01,0,1,8'h00), 1,
          w(0,1,0,3'b000,0,0,0,0,3'b011,2'b01,1,0,8'h00), 0);
      run("lbu_abort", 7'b0000011, 3'b100, 7'b0000000, 0,0,0,0,
          w(0,1,0,3'b000,0,0,0,0,3'b100,2'b01,0,1,8'h00), 1, '0, 1);
      run("addi_after_reset", 7'b0010011, 3'b000, 7'b0000000, 0,0,0,0,
          w(0,1,0,3'b000,0,0,0,0,3'b000,2'b00,1,0,8'h00), 0, '0, 0);

      push("final_fetch", {1'b1, 1'b0, 25'd0}, 0);
      wait_ime("final");
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain got=%0d exp=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
